// File: rtl/bcd_time_pkg.sv
// Shared types and helpers for the BCD mm:ss time counter.
package bcd_time_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam int SEC_MAX = 59;

   // A load word is usable only if every nibble is a decimal digit, the
   // tens-of-seconds digit is 0..5, and the minutes value fits in min_max.
   function automatic logic load_val_ok(input logic [15:0] val, input int min_max);
      int min_val;
      min_val = int'(val[15:12]) * 10 + int'(val[11:8]);
      return (val[15:12] <= 4'd9) && (val[11:8] <= 4'd9) &&
             (val[7:4] <= 4'd5) && (val[3:0] <= 4'd9) &&
             (min_val <= min_max);
   endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD up/down counter running modulo MAX+1.
// carry/borrow flag that the next step in the current direction wraps; they
// are not qualified by en so the parent can also use them to detect end stops.
module bcd_digit_pair
   import bcd_time_pkg::*;
#(
   parameter int MAX = 59
) (
   input  logic       clk_used,
   input  logic       rst_n,
   input  logic       en,
   input  logic       dir,
   input  logic       load,
   input  logic [7:0] load_val,
   output bcd_digit_t top,
   output bcd_digit_t bot,
   output logic       carry,
   output logic       borrow
);

   localparam bcd_digit_t MAX_TOP = 4'(MAX / 10);
   localparam bcd_digit_t MAX_BOT = 4'(MAX % 10);

   bcd_digit_t top_q, top_d;
   bcd_digit_t bot_q, bot_d;
   logic       at_max;
   logic       at_zero;

   assign at_max  = (top_q == MAX_TOP) && (bot_q == MAX_BOT);
   assign at_zero = (top_q == 4'd0) && (bot_q == 4'd0);
   assign carry   = dir & at_max;
   assign borrow  = ~dir & at_zero;
   assign top     = top_q;
   assign bot     = bot_q;

   // next digit value: load wins, otherwise a single step in dir when enabled
   always_comb begin
      top_d = top_q;
      bot_d = bot_q;
      if (load) begin
         top_d = load_val[7:4];
         bot_d = load_val[3:0];
      end else if (en) begin
         if (dir) begin
            if (at_max) begin
               top_d = 4'd0;
               bot_d = 4'd0;
            end else if (bot_q == 4'd9) begin
               top_d = top_q + 4'd1;
               bot_d = 4'd0;
            end else begin
               bot_d = bot_q + 4'd1;
            end
         end else begin
            if (at_zero) begin
               top_d = MAX_TOP;
               bot_d = MAX_BOT;
            end else if (bot_q == 4'd0) begin
               top_d = top_q - 4'd1;
               bot_d = 4'd9;
            end else begin
               bot_d = bot_q - 4'd1;
            end
         end
      end
   end

   // digit registers
   always_ff @(posedge clk_used or negedge rst_n) begin
      if (!rst_n) begin
         top_q <= 4'd0;
         bot_q <= 4'd0;
      end else begin
         top_q <= top_d;
         bot_q <= bot_d;
      end
   end

endmodule

// File: rtl/bcd_time_counter.sv
// mm:ss BCD time counter with load, adjust and run modes.
// Priority each cycle: load > adjust > run; losing events are dropped.
module bcd_time_counter
   import bcd_time_pkg::*;
#(
   parameter int MIN_MAX   = 99,
   parameter int WRAP_MODE = 1
) (
   input  logic        clk_used,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        adj_tick,
   input  logic        is_running,
   input  logic        is_fwd_or_bkwd,
   input  logic        adj,
   input  logic        sel,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [3:0]  minutes_top_digit,
   output logic [3:0]  minutes_bot_digit,
   output logic [3:0]  seconds_top_digit,
   output logic [3:0]  seconds_bot_digit,
   output logic        at_zero,
   output logic        at_max,
   output logic        expired,
   output logic        rollover,
   output logic        load_err
);

   localparam bcd_digit_t MIN_TOP = 4'(MIN_MAX / 10);
   localparam bcd_digit_t MIN_BOT = 4'(MIN_MAX % 10);
   localparam bcd_digit_t SEC_TOP = 4'(SEC_MAX / 10);
   localparam bcd_digit_t SEC_BOT = 4'(SEC_MAX % 10);

   bcd_digit_t min_top, min_bot, sec_top, sec_bot;
   logic       sec_carry, sec_borrow, min_carry, min_borrow;
   logic       load_ok, load_acc, adj_fire, run_fire, run_blocked, run_step;
   logic       sec_en, min_en;
   logic       expired_q, expired_d;
   logic       rollover_q, rollover_d;
   logic       load_err_q, load_err_d;

   assign load_ok  = load_val_ok(load_val, MIN_MAX);
   assign load_acc = load & load_ok;
   assign adj_fire = ~load & adj & adj_tick;
   assign run_fire = ~load & ~adj & is_running & tick;

   // Up-count stops at the top only when not wrapping; down-count always
   // stops at 00:00.
   assign run_blocked = (sec_carry & min_carry & (WRAP_MODE == 0)) |
                        (sec_borrow & min_borrow);
   assign run_step    = run_fire & ~run_blocked;

   // Adjust steps one field in isolation; run mode ripples seconds into minutes.
   assign sec_en = run_step | (adj_fire & sel);
   assign min_en = (run_step & (sec_carry | sec_borrow)) | (adj_fire & ~sel);

   bcd_digit_pair #(.MAX(SEC_MAX)) u_sec (
      .clk_used (clk_used),
      .rst_n    (rst_n),
      .en       (sec_en),
      .dir      (is_fwd_or_bkwd),
      .load     (load_acc),
      .load_val (load_val[7:0]),
      .top      (sec_top),
      .bot      (sec_bot),
      .carry    (sec_carry),
      .borrow   (sec_borrow)
   );

   bcd_digit_pair #(.MAX(MIN_MAX)) u_min (
      .clk_used (clk_used),
      .rst_n    (rst_n),
      .en       (min_en),
      .dir      (is_fwd_or_bkwd),
      .load     (load_acc),
      .load_val (load_val[15:8]),
      .top      (min_top),
      .bot      (min_bot),
      .carry    (min_carry),
      .borrow   (min_borrow)
   );

   assign minutes_top_digit = min_top;
   assign minutes_bot_digit = min_bot;
   assign seconds_top_digit = sec_top;
   assign seconds_bot_digit = sec_bot;

   assign at_zero = (min_top == 4'd0) && (min_bot == 4'd0) &&
                    (sec_top == 4'd0) && (sec_bot == 4'd0);
   assign at_max  = (min_top == MIN_TOP) && (min_bot == MIN_BOT) &&
                    (sec_top == SEC_TOP) && (sec_bot == SEC_BOT);

   assign expired  = expired_q;
   assign rollover = rollover_q;
   assign load_err = load_err_q;

   // event pulses; expired fires when a run-mode down step leaves 00:01
   always_comb begin
      expired_d  = run_step & ~is_fwd_or_bkwd &
                   (min_top == 4'd0) && (min_bot == 4'd0) &&
                   (sec_top == 4'd0) && (sec_bot == 4'd1);
      rollover_d = run_step & sec_carry & min_carry;
      load_err_d = load & ~load_ok;
   end

   // pulse registers, each high for exactly one cycle
   always_ff @(posedge clk_used or negedge rst_n) begin
      if (!rst_n) begin
         expired_q  <= 1'b0;
         rollover_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         expired_q  <= expired_d;
         rollover_q <= rollover_d;
         load_err_q <= load_err_d;
      end
   end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: three parameterisations driven in parallel,
// expected values from a seconds-count model pushed to a scoreboard queue.
module tb_bcd_time_counter;

   typedef struct packed {
      logic [15:0] d;
      logic        az;
      logic        am;
      logic        ex;
      logic        ro;
      logic        le;
   } obs_t;

   localparam int N_DUT = 3;
   localparam int MM [N_DUT] = '{99, 99, 59};
   localparam int WR [N_DUT] = '{1, 0, 1};
   localparam obs_t RESET_OBS = '{d: 16'h0000, az: 1'b1, am: 1'b0, ex: 1'b0, ro: 1'b0, le: 1'b0};

   logic        clk_used = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0, adj_tick = 1'b0, is_running = 1'b0, is_fwd_or_bkwd = 1'b0;
   logic        adj = 1'b0, sel = 1'b0, load = 1'b0;
   logic [15:0] load_val = 16'h0000;

   logic [3:0] mt [N_DUT], mb [N_DUT], st [N_DUT], sb [N_DUT];
   logic       az [N_DUT], am [N_DUT], ex [N_DUT], ro [N_DUT], le [N_DUT];
   obs_t       act [N_DUT];

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   obs_t exp_q [$];
   int   m_min [N_DUT];
   int   m_sec [N_DUT];

   always #5 clk_used = ~clk_used;

   bcd_time_counter #(.MIN_MAX(99), .WRAP_MODE(1)) u_dut0 (
      .clk_used(clk_used), .rst_n(rst_n), .tick(tick), .adj_tick(adj_tick),
      .is_running(is_running), .is_fwd_or_bkwd(is_fwd_or_bkwd), .adj(adj), .sel(sel),
      .load(load), .load_val(load_val),
      .minutes_top_digit(mt[0]), .minutes_bot_digit(mb[0]),
      .seconds_top_digit(st[0]), .seconds_bot_digit(sb[0]),
      .at_zero(az[0]), .at_max(am[0]), .expired(ex[0]), .rollover(ro[0]), .load_err(le[0]));

   bcd_time_counter #(.MIN_MAX(99), .WRAP_MODE(0)) u_dut1 (
      .clk_used(clk_used), .rst_n(rst_n), .tick(tick), .adj_tick(adj_tick),
      .is_running(is_running), .is_fwd_or_bkwd(is_fwd_or_bkwd), .adj(adj), .sel(sel),
      .load(load), .load_val(load_val),
      .minutes_top_digit(mt[1]), .minutes_bot_digit(mb[1]),
      .seconds_top_digit(st[1]), .seconds_bot_digit(sb[1]),
      .at_zero(az[1]), .at_max(am[1]), .expired(ex[1]), .rollover(ro[1]), .load_err(le[1]));

   bcd_time_counter #(.MIN_MAX(59), .WRAP_MODE(1)) u_dut2 (
      .clk_used(clk_used), .rst_n(rst_n), .tick(tick), .adj_tick(adj_tick),
      .is_running(is_running), .is_fwd_or_bkwd(is_fwd_or_bkwd), .adj(adj), .sel(sel),
      .load(load), .load_val(load_val),
      .minutes_top_digit(mt[2]), .minutes_bot_digit(mb[2]),
      .seconds_top_digit(st[2]), .seconds_bot_digit(sb[2]),
      .at_zero(az[2]), .at_max(am[2]), .expired(ex[2]), .rollover(ro[2]), .load_err(le[2]));

   for (genvar g = 0; g < N_DUT; g++) begin : g_act
      assign act[g] = {mt[g], mb[g], st[g], sb[g], az[g], am[g], ex[g], ro[g], le[g]};
   end

   task automatic check_obs(input string name, input obs_t a, input obs_t e);
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s cyc%0d actual=%h required=%h", name, cyc, a, e);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N_DUT; i++) begin
         m_min[i] = 0;
         m_sec[i] = 0;
      end
   endfunction

   // Behavioural reference: time kept as minutes/seconds integers.
   function automatic obs_t model_step(input int i, input logic t, input logic at,
                                       input logic run, input logic dir, input logic a,
                                       input logic s, input logic ld, input logic [15:0] lv);
      obs_t o;
      int   mn, sc, tot, tmax;
      int   d3, d2, d1, d0;
      logic pex, pro, ple;
      mn = m_min[i]; sc = m_sec[i];
      tmax = MM[i] * 60 + 59;
      pex = 1'b0; pro = 1'b0; ple = 1'b0;
      if (ld) begin
         d3 = int'(lv[15:12]); d2 = int'(lv[11:8]); d1 = int'(lv[7:4]); d0 = int'(lv[3:0]);
         if (d3 <= 9 && d2 <= 9 && d1 <= 5 && d0 <= 9 && d3 * 10 + d2 <= MM[i]) begin
            mn = d3 * 10 + d2;
            sc = d1 * 10 + d0;
         end else begin
            ple = 1'b1;
         end
      end else if (a && at) begin
         if (s) sc = dir ? (sc + 1) % 60 : (sc + 59) % 60;
         else   mn = dir ? (mn + 1) % (MM[i] + 1) : (mn + MM[i]) % (MM[i] + 1);
      end else if (!a && run && t) begin
         tot = mn * 60 + sc;
         if (dir) begin
            if (tot == tmax) begin
               if (WR[i] != 0) begin
                  tot = 0;
                  pro = 1'b1;
               end
            end else begin
               tot++;
            end
         end else if (tot > 0) begin
            tot--;
            if (tot == 0) pex = 1'b1;
         end
         mn = tot / 60;
         sc = tot % 60;
      end
      m_min[i] = mn;
      m_sec[i] = sc;
      o.d  = {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
      o.az = (mn == 0) && (sc == 0);
      o.am = (mn * 60 + sc) == tmax;
      o.ex = pex;
      o.ro = pro;
      o.le = ple;
      return o;
   endfunction

   // Apply one cycle of inputs and queue the expected post-edge state.
   task automatic drive(input logic t, input logic at, input logic run, input logic dir,
                        input logic a, input logic s, input logic ld, input logic [15:0] lv);
      @(negedge clk_used);
      tick = t; adj_tick = at; is_running = run; is_fwd_or_bkwd = dir;
      adj = a; sel = s; load = ld; load_val = lv;
      for (int i = 0; i < N_DUT; i++)
         exp_q.push_back(model_step(i, t, at, run, dir, a, s, ld, lv));
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   // monitor: whenever expectations are pending, compare all DUTs after the edge
   initial begin
      forever begin
         @(posedge clk_used);
         #1;
         cyc++;
         if (exp_q.size() >= N_DUT) begin
            for (int i = 0; i < N_DUT; i++) begin
               obs_t e;
               e = exp_q.pop_front();
               check_obs($sformatf("dut%0d", i), act[i], e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] lv;
      model_reset();
      #12;
      for (int i = 0; i < N_DUT; i++) check_obs($sformatf("reset_dut%0d", i), act[i], RESET_OBS);
      @(negedge clk_used);
      rst_n = 1'b1;

      // top-of-range up count: wrap vs saturate (minutes 99 invalid for dut2)
      drive(0, 0, 0, 1, 0, 0, 1, 16'h9959);
      repeat (3) drive(1, 0, 1, 1, 0, 0, 0, 16'h0000);
      idle();

      // countdown to expiry and hold
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0003);
      repeat (4) drive(1, 0, 1, 0, 0, 0, 0, 16'h0000);
      idle();

      // minutes adjust down from 00 wraps to MIN_MAX; seconds adjust up 59->00
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0030);
      drive(0, 1, 0, 0, 1, 0, 0, 16'h0000);
      drive(0, 0, 0, 0, 0, 0, 1, 16'h5959);
      drive(0, 1, 1, 1, 1, 1, 0, 16'h0000);
      drive(1, 0, 1, 1, 1, 1, 0, 16'h0000);

      // illegal load, then load colliding with a run tick
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0A00);
      drive(1, 0, 1, 1, 0, 0, 1, 16'h1234);
      drive(0, 0, 0, 0, 0, 0, 1, 16'h1260);
      idle();

      // asynchronous reset between edges at 12:34
      @(posedge clk_used);
      #3;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < N_DUT; i++) check_obs($sformatf("midreset_dut%0d", i), act[i], RESET_OBS);
      model_reset();
      @(negedge clk_used);
      rst_n = 1'b1;
      drive(1, 0, 1, 1, 0, 0, 0, 16'h0000);
      drive(1, 0, 1, 0, 0, 0, 0, 16'h0000);
      drive(1, 0, 1, 0, 0, 0, 0, 16'h0000);

      // randomized traffic, biased toward near-legal load values and ends of range
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(3) == 0) lv = 16'($urandom);
         else if ($urandom_range(3) == 0)
            lv = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'd5, 4'($urandom_range(9))};
         else if ($urandom_range(4) == 0) lv = ($urandom_range(1) != 0) ? 16'h0001 : 16'h5958;
         else
            lv = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(6)),
                  4'($urandom_range(9))};
         drive(1'($urandom_range(1)), 1'($urandom_range(3) == 0), 1'($urandom_range(7) != 0),
               1'($urandom_range(1)), 1'($urandom_range(4) == 0), 1'($urandom_range(1)),
               1'($urandom_range(15) == 0), lv);
      end
      idle();

      @(posedge clk_used);
      #3;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
